fluid_board_soc_shared_mailbox_ram: RTL and testbench

//  True dual-port shared RAM between the NIOS fluid controller (port A) and the ARM host (port B).

---
 rtl/fluid_board_soc_mem_pkg.sv | 22 ++
 rtl/fluid_board_soc_rd_pipe.sv | 45 ++++
 rtl/fluid_board_soc_shared_mailbox_ram.sv | 157 +++++++++++++++
 tb/tb_fluid_board_soc_shared_mailbox_ram.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fluid_board_soc_mem_pkg.sv
// Shared defaults and legality helpers for the fluid-board mailbox RAM.
//   DEF_*       : default data width, address width and read latency
//   RL_MIN/MAX  : legal read-latency range
//   DB_*_OFS    : doorbell word offsets counted down from the top of the array
package fluid_board_soc_mem_pkg;

    localparam int unsigned DEF_DATA_W       = 16;
    localparam int unsigned DEF_ADDR_W       = 14;
    localparam int unsigned DEF_READ_LATENCY = 1;

    localparam int unsigned RL_MIN = 1;
    localparam int unsigned RL_MAX = 2;

    localparam int unsigned DB_A2B_OFS = 1;
    localparam int unsigned DB_B2A_OFS = 2;

    // True when the requested read latency can be built.
    function automatic bit rl_legal(input int unsigned rl);
        return (rl >= RL_MIN) && (rl <= RL_MAX);
    endfunction

endpackage

// File: rtl/fluid_board_soc_rd_pipe.sv
// Read-return delay line: shifts a valid strobe and its data DEPTH cycles.
//   clk, reset : clock, asynchronous active-high reset (flushes all stages)
//   i_valid/i_data : strobe and data entering the line
//   o_valid/o_data : strobe and data leaving the line (pass-through when DEPTH=0)
module fluid_board_soc_rd_pipe #(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    if (DEPTH == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = clk ^ reset;
        assign o_valid  = i_valid;
        assign o_data   = i_data;
    end else begin : g_shift
        logic [DEPTH-1:0] r_valid;
        logic [W-1:0]     r_data [DEPTH];

        // Stage 0 takes the input; later stages follow their predecessor.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= '0;
                for (int i = 0; i < int'(DEPTH); i++) r_data[i] <= '0;
            end else begin
                r_valid[0] <= i_valid;
                r_data[0]  <= i_data;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    r_valid[i] <= r_valid[i-1];
                    r_data[i]  <= r_data[i-1];
                end
            end
        end

        assign o_valid = r_valid[DEPTH-1];
        assign o_data  = r_data[DEPTH-1];
    end

endmodule

// File: rtl/fluid_board_soc_shared_mailbox_ram.sv
// True dual-port shared RAM between the NIOS fluid controller (port A) and
// the ARM host (port B), with Avalon-MM handshakes, same-address collision
// ordering and one sticky doorbell IRQ per direction.
//   clk, reset, reset_req           : clock, async reset, sync access freeze
//   a_/b_ address, byteenable,
//     chipselect, read, write,
//     writedata                     : Avalon-MM slave command inputs
//   a_/b_ readdata, readdatavalid   : read return (READ_LATENCY after accept)
//   a_/b_ waitrequest               : stall
//   irq_a / irq_b                   : doorbell from B / from A
module fluid_board_soc_shared_mailbox_ram
    import fluid_board_soc_mem_pkg::*;
#(
    parameter int unsigned       DATA_W       = DEF_DATA_W,
    parameter int unsigned       ADDR_W       = DEF_ADDR_W,
    parameter int unsigned       READ_LATENCY = DEF_READ_LATENCY,
    parameter logic [ADDR_W-1:0] DB_A2B_ADDR  = ADDR_W'((2**ADDR_W) - DB_A2B_OFS),
    parameter logic [ADDR_W-1:0] DB_B2A_ADDR  = ADDR_W'((2**ADDR_W) - DB_B2A_OFS),
    parameter string             INIT_FILE    = "fluid_board_soc_shared_mailbox_ram.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,

    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic                a_chipselect,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,
    output logic                a_waitrequest,
    output logic                irq_a,

    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic                b_chipselect,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,
    output logic                b_waitrequest,
    output logic                irq_b
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned DEPTH  = 2**ADDR_W;

    // Elaboration-time parameter sanity.
    if (DATA_W % 8 != 0) begin : g_err_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (!rl_legal(READ_LATENCY)) begin : g_err_rl
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DB_A2B_ADDR == DB_B2A_ADDR) begin : g_err_db
        $error("doorbell addresses must differ");
    end
    // The power-up image is bound by the memory implementation flow.
    if (INIT_FILE == "") begin : g_err_init
        $error("INIT_FILE must name a power-up image");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_a_acc, w_a_acc_rd, w_a_acc_wr;
    logic w_b_acc, w_b_acc_rd, w_b_acc_wr;
    logic w_coll;
    logic r_coll_q;
    logic r_a_rvalid, r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata, r_b_rdata;
    logic r_irq_a, r_irq_b;
    logic w_set_a, w_clr_a, w_set_b, w_clr_b;

    // B is held off one cycle when A writes the word B is touching; the
    // r_coll_q term guarantees the retry is never stalled a second time.
    assign w_coll = w_a_acc_wr & b_chipselect & (b_read | b_write)
                  & (a_address == b_address) & ~r_coll_q;

    assign a_waitrequest = reset | reset_req;
    assign b_waitrequest = reset | reset_req | w_coll;

    assign w_a_acc    = a_chipselect & (a_read | a_write) & ~a_waitrequest;
    assign w_a_acc_rd = w_a_acc & a_read;
    assign w_a_acc_wr = w_a_acc & a_write;
    assign w_b_acc    = b_chipselect & (b_read | b_write) & ~b_waitrequest;
    assign w_b_acc_rd = w_b_acc & b_read;
    assign w_b_acc_wr = w_b_acc & b_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_coll_q <= 1'b0;
        else       r_coll_q <= w_coll;
    end

    // Byte-lane writes; B is applied after A so B's lanes win a tie.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (w_a_acc_wr && a_byteenable[i]) r_mem[a_address][i*8 +: 8] <= a_writedata[i*8 +: 8];
            if (w_b_acc_wr && b_byteenable[i]) r_mem[b_address][i*8 +: 8] <= b_writedata[i*8 +: 8];
        end
    end

    // First read stage: captures the pre-edge word on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rvalid <= 1'b0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= w_a_acc_rd;
            r_b_rvalid <= w_b_acc_rd;
            if (w_a_acc_rd) r_a_rdata <= r_mem[a_address];
            if (w_b_acc_rd) r_b_rdata <= r_mem[b_address];
        end
    end

    fluid_board_soc_rd_pipe #(.DEPTH(READ_LATENCY - 1), .W(DATA_W)) u_a_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_a_rvalid),
        .i_data  (r_a_rdata),
        .o_valid (a_readdatavalid),
        .o_data  (a_readdata)
    );

    fluid_board_soc_rd_pipe #(.DEPTH(READ_LATENCY - 1), .W(DATA_W)) u_b_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_b_rvalid),
        .i_data  (r_b_rdata),
        .o_valid (b_readdatavalid),
        .o_data  (b_readdata)
    );

    // Doorbells: the writer rings, the peer's read of the word acknowledges.
    assign w_set_b = w_a_acc_wr & (a_address == DB_A2B_ADDR);
    assign w_clr_b = w_b_acc_rd & (b_address == DB_A2B_ADDR);
    assign w_set_a = w_b_acc_wr & (b_address == DB_B2A_ADDR);
    assign w_clr_a = w_a_acc_rd & (a_address == DB_B2A_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_a <= 1'b0;
            r_irq_b <= 1'b0;
        end else begin
            r_irq_a <= w_set_a | (r_irq_a & ~w_clr_a);
            r_irq_b <= w_set_b | (r_irq_b & ~w_clr_b);
        end
    end

    assign irq_a = r_irq_a;
    assign irq_b = r_irq_b;

endmodule

// File: tb/tb_fluid_board_soc_shared_mailbox_ram.sv
module tb_fluid_board_soc_shared_mailbox_ram;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 14;
    localparam int          RL = 2;
    localparam logic [AW-1:0] DB_A2B = 14'h3FFF;
    localparam logic [AW-1:0] DB_B2A = 14'h3FFE;

    typedef struct packed {
        logic          cs;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [1:0]    be;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_req = 1'b0;
    logic [AW-1:0] a_address = '0, b_address = '0;
    logic [1:0]    a_byteenable = '0, b_byteenable = '0;
    logic          a_chipselect = 1'b0, a_read = 1'b0, a_write = 1'b0;
    logic          b_chipselect = 1'b0, b_read = 1'b0, b_write = 1'b0;
    logic [DW-1:0] a_writedata = '0, b_writedata = '0;
    logic [DW-1:0] a_readdata, b_readdata;
    logic          a_readdatavalid, b_readdatavalid;
    logic          a_waitrequest, b_waitrequest;
    logic          irq_a, irq_b;

    always #5 clk = ~clk;

    fluid_board_soc_shared_mailbox_ram #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_chipselect(a_chipselect),
        .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .a_waitrequest(a_waitrequest), .irq_a(irq_a),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_chipselect(b_chipselect),
        .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .b_waitrequest(b_waitrequest), .irq_b(irq_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: word array, doorbell flags, queued read returns.
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    bit   m_irq_a, m_irq_b, m_prev_coll;
    exp_t qa[$];
    exp_t qb[$];

    logic [AW-1:0] pool [8] = '{14'h0010, 14'h0020, 14'h0030, 14'h0040,
                                14'h0000, 14'h1234, DB_A2B, DB_B2A};
    localparam cmd_t IDLE = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit req(input cmd_t c);
        return c.cs && (c.rd || c.wr);
    endfunction

    function automatic cmd_t mk_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] be);
        cmd_t c = '0;
        c.cs = 1'b1; c.wr = 1'b1; c.addr = addr; c.data = data; c.be = be;
        return c;
    endfunction

    function automatic cmd_t mk_rd(input logic [AW-1:0] addr);
        cmd_t c = '0;
        c.cs = 1'b1; c.rd = 1'b1; c.addr = addr; c.be = 2'b11;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.cs   = ($urandom_range(0, 3) != 0);
        c.rd   = ($urandom_range(0, 1) == 1);
        c.wr   = !c.rd;
        c.addr = pool[$urandom_range(0, 7)];
        c.be   = 2'($urandom_range(0, 3));
        c.data = 16'($urandom);
        return c;
    endfunction

    task automatic model_write(input cmd_t c);
        for (int i = 0; i < 2; i++)
            if (c.be[i]) m_mem[c.addr][i*8 +: 8] = c.data[i*8 +: 8];
    endtask

    // One clock with the given commands; checks stall and IRQ outputs and
    // advances the model at the edge. Called and returns at posedge+1.
    task automatic cycle_once(input cmd_t a, input cmd_t b, output bit acc_a, output bit acc_b);
        bit coll, aw_exp, bw_exp, set_a, clr_a, set_b, clr_b;
        int now;
        a_chipselect = a.cs; a_read = a.rd; a_write = a.wr;
        a_address = a.addr; a_byteenable = a.be; a_writedata = a.data;
        b_chipselect = b.cs; b_read = b.rd; b_write = b.wr;
        b_address = b.addr; b_byteenable = b.be; b_writedata = b.data;
        aw_exp = reset || reset_req;
        acc_a  = req(a) && !aw_exp;
        coll   = acc_a && a.wr && req(b) && (a.addr == b.addr) && !m_prev_coll;
        bw_exp = aw_exp || coll;
        acc_b  = req(b) && !bw_exp;
        @(negedge clk);
        chk("a_waitrequest", 32'(a_waitrequest), 32'(aw_exp));
        chk("b_waitrequest", 32'(b_waitrequest), 32'(bw_exp));
        chk("irq_a", 32'(irq_a), 32'(m_irq_a));
        chk("irq_b", 32'(irq_b), 32'(m_irq_b));
        now = cyc;
        @(posedge clk);
        if (acc_a && a.rd) qa.push_back('{m_mem[a.addr], now + RL});
        if (acc_b && b.rd) qb.push_back('{m_mem[b.addr], now + RL});
        if (acc_a && a.wr) model_write(a);
        if (acc_b && b.wr) model_write(b);
        set_b = acc_a && a.wr && (a.addr == DB_A2B);
        clr_b = acc_b && b.rd && (b.addr == DB_A2B);
        set_a = acc_b && b.wr && (b.addr == DB_B2A);
        clr_a = acc_a && a.rd && (a.addr == DB_B2A);
        m_irq_b = set_b ? 1'b1 : (clr_b ? 1'b0 : m_irq_b);
        m_irq_a = set_a ? 1'b1 : (clr_a ? 1'b0 : m_irq_a);
        m_prev_coll = coll;
        #1;
    endtask

    // Avalon-style issue: each command is held until accepted.
    task automatic step(input cmd_t a, input cmd_t b);
        cmd_t ca = a, cb = b;
        bit aa, ab;
        int n = 0;
        while ((req(ca) || req(cb)) && n < 6) begin
            cycle_once(ca, cb, aa, ab);
            if (aa) ca = IDLE;
            if (ab) cb = IDLE;
            n++;
        end
        if (req(ca) || req(cb)) chk("step_accept_timeout", 32'(n), 32'(0));
    endtask

    // Scoreboard monitor: every return strobe must match the oldest due entry.
    always @(negedge clk) begin
        bit ev_a, ev_b;
        while (qa.size() > 0 && qa[0].due < cyc) begin
            chk("a_return_missing", 32'(qa[0].due), 32'(cyc));
            void'(qa.pop_front());
        end
        while (qb.size() > 0 && qb[0].due < cyc) begin
            chk("b_return_missing", 32'(qb[0].due), 32'(cyc));
            void'(qb.pop_front());
        end
        ev_a = (qa.size() > 0) && (qa[0].due == cyc);
        ev_b = (qb.size() > 0) && (qb[0].due == cyc);
        if (a_readdatavalid || ev_a) begin
            chk("a_readdatavalid", 32'(a_readdatavalid), 32'(ev_a));
            if (ev_a) begin
                if (a_readdatavalid) chk("a_readdata", 32'(a_readdata), 32'(qa[0].data));
                void'(qa.pop_front());
            end
        end
        if (b_readdatavalid || ev_b) begin
            chk("b_readdatavalid", 32'(b_readdatavalid), 32'(ev_b));
            if (ev_b) begin
                if (b_readdatavalid) chk("b_readdata", 32'(b_readdata), 32'(qb[0].data));
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        bit xa, xb;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_a_readdata", 32'(a_readdata), 32'(0));
        chk("rst_b_readdata", 32'(b_readdata), 32'(0));
        chk("rst_a_rvalid", 32'(a_readdatavalid), 32'(0));
        chk("rst_b_rvalid", 32'(b_readdatavalid), 32'(0));
        chk("rst_irq_a", 32'(irq_a), 32'(0));
        chk("rst_irq_b", 32'(irq_b), 32'(0));
        chk("rst_b_waitrequest", 32'(b_waitrequest), 32'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // Give every pooled word a known value.
        for (int i = 0; i < 8; i++) step(mk_wr(pool[i], 16'($urandom), 2'b11), IDLE);

        // Write on A, read back on B.
        step(mk_wr(14'h0010, 16'hBEEF, 2'b11), IDLE);
        step(IDLE, mk_rd(14'h0010));
        // A write collides with B read: B sees A's new data.
        step(mk_wr(14'h0020, 16'h1234, 2'b11), mk_rd(14'h0020));
        // Both write the same word: B's data remains.
        step(mk_wr(14'h0030, 16'h1111, 2'b11), mk_wr(14'h0030, 16'h2222, 2'b11));
        step(IDLE, mk_rd(14'h0030));

        // Doorbells.
        step(IDLE, mk_rd(DB_A2B));
        chk("db_irq_b_cleared", 32'(irq_b), 32'(0));
        step(mk_wr(DB_A2B, 16'h0001, 2'b11), IDLE);
        chk("db_irq_b_set", 32'(irq_b), 32'(1));
        step(IDLE, mk_rd(DB_A2B));
        chk("db_irq_b_ack", 32'(irq_b), 32'(0));
        cycle_once(mk_wr(DB_A2B, 16'h0002, 2'b11), mk_rd(DB_A2B), xa, xb);
        cycle_once(mk_wr(DB_A2B, 16'h0003, 2'b11), mk_rd(DB_A2B), xa, xb);
        chk("db_set_beats_clear", 32'(irq_b), 32'(1));
        step(IDLE, mk_wr(DB_B2A, 16'h00A5, 2'b11));
        chk("db_irq_a_set", 32'(irq_a), 32'(1));
        step(mk_rd(DB_B2A), IDLE);
        chk("db_irq_a_ack", 32'(irq_a), 32'(0));

        // Byte lanes.
        step(mk_wr(14'h0040, 16'hAABB, 2'b01), IDLE);
        step(mk_wr(14'h0040, 16'hCC00, 2'b10), IDLE);
        step(IDLE, mk_rd(14'h0040));

        for (int i = 0; i < 300; i++) step(rnd_cmd(), rnd_cmd());

        // reset_req freeze with a read in flight; frozen writes are dropped.
        cycle_once(mk_rd(14'h0040), IDLE, xa, xb);
        reset_req = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle_once(mk_wr(14'h0010, 16'($urandom), 2'b11), mk_wr(14'h0020, 16'($urandom), 2'b11), xa, xb);
        reset_req = 1'b0;
        step(mk_rd(14'h0010), mk_rd(14'h0020));

        // Reset while a read is in flight drops its return and clears IRQs.
        step(mk_wr(DB_A2B, 16'h0F0F, 2'b11), IDLE);
        step(IDLE, mk_wr(DB_B2A, 16'hF0F0, 2'b11));
        cycle_once(IDLE, mk_rd(14'h0010), xa, xb);
        reset = 1'b1;
        qa.delete(); qb.delete();
        m_irq_a = 1'b0; m_irq_b = 1'b0; m_prev_coll = 1'b0;
        for (int i = 0; i < 3; i++) cycle_once(IDLE, IDLE, xa, xb);
        chk("reset_irq_b", 32'(irq_b), 32'(0));
        chk("reset_irq_a", 32'(irq_a), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle_once(IDLE, IDLE, xa, xb);

        for (int i = 0; i < 150; i++) step(rnd_cmd(), rnd_cmd());

        for (int i = 0; i < 8 && (qa.size() > 0 || qb.size() > 0); i++) cycle_once(IDLE, IDLE, xa, xb);
        chk("drain_pending", 32'(qa.size() + qb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
